// File: rtl/posit_accum_stream_if.sv
// Stream bundle for the posit accumulator: operand beats in, one packet sum out.
interface posit_accum_stream_if #(
    parameter int NBITS = 32,
    parameter int CNT_W = 16
);
    logic [NBITS-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [NBITS-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_inf;
    logic             out_zero;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_inf, out_zero, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_inf, out_zero, out_valid
    );
endinterface

// File: rtl/posit_accum_stream.sv
// Streaming posit accumulator: sums each in_last-delimited packet of posit
// operands through one combinational positadd in a feedback loop.
module positadd #(
    parameter int NBITS = 32,
    parameter int ES    = 2
) (
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    output logic [NBITS-1:0] result
);
    localparam int FW   = NBITS - 2 - ES;
    localparam int MW   = FW + 1;
    localparam int AW   = 2 * NBITS;
    localparam int GW   = AW - 1 - MW;
    localparam int EW   = 2 * AW;
    localparam int TW   = ES + AW - 1;
    localparam int MAXS = (NBITS - 2) * (2 ** ES);
    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    function automatic int unsigned clz(input logic [AW-1:0] x);
        clz = AW;
        for (int unsigned i = 0; i < AW; i++)
            if (x[i]) clz = AW - 1 - i;
    endfunction

    function automatic void decode(input logic [NBITS-1:0] p, output logic sgn,
                                   output int sc, output logic [MW-1:0] mant);
        logic [NBITS-2:0] rem;
        logic [NBITS-2:0] run;
        logic [NBITS-3:0] tmp;
        int unsigned      m;
        int               k;
        sgn = p[NBITS-1];
        rem = (NBITS-1)'(sgn ? -p : p);
        run = rem[NBITS-2] ? ~rem : rem;
        m   = clz({run, {(AW-NBITS+1){1'b0}}});
        if (m > NBITS - 1) m = NBITS - 1;
        k    = rem[NBITS-2] ? int'(m) - 1 : -int'(m);
        // Drop the regime run; the terminator falls off the top of tmp.
        tmp  = (NBITS-2)'(rem << m);
        sc   = k * (2 ** ES) + int'(tmp[NBITS-3 -: ES]);
        mant = {1'b1, tmp[FW-1:0]};
    endfunction

    function automatic logic [NBITS-1:0] padd(input logic [NBITS-1:0] a,
                                              input logic [NBITS-1:0] b);
        logic             sa, sb, sbig, ssml, sticky, rnd;
        int               ea, eb, ebig, d, s, k, rlen;
        int unsigned      lz;
        logic [MW-1:0]    ma, mb;
        logic [AW-1:0]    big, sml, shf, sum, norm;
        logic [EW-1:0]    y;
        logic [TW-1:0]    tail;
        logic [NBITS-2:0] body;
        if (a == NAR || b == NAR) return NAR;
        if (a == '0) return b;
        if (b == '0) return a;
        decode(a, sa, ea, ma);
        decode(b, sb, eb, mb);
        if (ea > eb || (ea == eb && ma >= mb)) begin
            sbig = sa; ssml = sb; ebig = ea; d = ea - eb;
            big  = {1'b0, ma, {GW{1'b0}}};
            sml  = {1'b0, mb, {GW{1'b0}}};
        end else begin
            sbig = sb; ssml = sa; ebig = eb; d = eb - ea;
            big  = {1'b0, mb, {GW{1'b0}}};
            sml  = {1'b0, ma, {GW{1'b0}}};
        end
        if (d >= AW) begin
            shf    = '0;
            sticky = 1'b1;
        end else begin
            shf    = sml >> d;
            sticky = ((shf << d) != sml);
        end
        // Guard bits sit far below the rounding point, so folding sticky into the LSB is exact enough.
        shf[0] = shf[0] | sticky;
        sum    = (sbig == ssml) ? big + shf : big - shf;
        if (sum == '0) return '0;
        lz   = clz(sum);
        norm = sum << lz;
        s    = ebig + 1 - int'(lz);
        if (s > MAXS) begin
            body = '1;
        end else if (s < -MAXS) begin
            body = {{(NBITS-2){1'b0}}, 1'b1};
        end else begin
            k    = s >>> ES;
            tail = {s[ES-1:0], norm[AW-2:0]};
            if (k >= 0) begin
                y    = ~({EW{1'b1}} >> (k + 1));
                rlen = k + 2;
            end else begin
                y    = {1'b1, {(EW-1){1'b0}}} >> (-k);
                rlen = 1 - k;
            end
            y    = y | ({tail, {(EW-TW){1'b0}}} >> rlen);
            body = y[EW-1 -: NBITS-1];
            rnd  = y[EW-NBITS] & ((|y[EW-NBITS-1:0]) | body[0]);
            body = body + (NBITS-1)'(rnd);
        end
        return sbig ? -{1'b0, body} : {1'b0, body};
    endfunction

    always_comb result = padd(in1, in2);
endmodule

module posit_accum_stream #(
    parameter int NBITS = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    posit_accum_stream_if.slave  bus
);
    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, RESULT} state_t;

    state_t           r_state, w_next;
    logic [NBITS-1:0] r_acc;
    logic             r_nar;
    logic [CNT_W-1:0] r_cnt;
    logic [NBITS-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_inf;
    logic             r_out_zero;

    logic             w_accept, w_in_ready;
    logic             w_in_nar, w_in_zero;
    logic [NBITS-1:0] w_acc_cur, w_sum, w_nxt;
    logic             w_nar_cur, w_nar_nxt;
    logic [CNT_W-1:0] w_cnt_cur, w_cnt_inc;

    // A new packet always starts from an empty accumulator, whatever r_* holds.
    always_comb begin
        w_acc_cur = (r_state == IDLE) ? '0 : r_acc;
        w_nar_cur = (r_state == IDLE) ? 1'b0 : r_nar;
        w_cnt_cur = (r_state == IDLE) ? '0 : r_cnt;
    end

    assign w_in_nar  = (bus.in_data == NAR);
    assign w_in_zero = (bus.in_data == '0);
    assign w_accept  = bus.in_valid & w_in_ready;

    positadd #(.NBITS(NBITS), .ES(2)) u_add (
        .in1    (w_acc_cur),
        .in2    (bus.in_data),
        .result (w_sum)
    );

    // Zero and NaR operands never reach the adder; a zero accumulator passes the beat through.
    always_comb begin
        w_nxt = w_acc_cur;
        if (!w_in_nar && !w_in_zero)
            w_nxt = (w_acc_cur == '0) ? bus.in_data : w_sum;
        w_nar_nxt = w_nar_cur | w_in_nar;
        w_cnt_inc = (w_cnt_cur == '1) ? w_cnt_cur : w_cnt_cur + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b1;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept) w_next = bus.in_last ? RESULT : ACC;
            end
            RESULT: begin
                w_in_ready = 1'b0;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_nar       <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_inf   <= 1'b0;
            r_out_zero  <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_last) begin
                r_out_data  <= w_nar_nxt ? NAR : w_nxt;
                r_out_inf   <= w_nar_nxt;
                r_out_zero  <= (w_nxt == '0) & ~w_nar_nxt;
                r_out_count <= w_cnt_inc;
                r_acc       <= '0;
                r_nar       <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_acc <= w_nxt;
                r_nar <= w_nar_nxt;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = (r_state == RESULT);
        bus.out_data  = r_out_data;
        bus.out_count = r_out_count;
        bus.out_inf   = r_out_inf;
        bus.out_zero  = r_out_zero;
    end
endmodule
